// File: rtl/bcd_field_writer_if.sv
// Bundle for the field writer: commit/data inputs from the counter side and
// the register-bus write handshake plus status flags.
interface bcd_field_writer_if;
    logic       W_R;
    logic [6:0] dato_bin;
    logic [7:0] addr_in;
    logic       wr_ack;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       range_err;
    logic       timeout_err;

    // master: the writer block itself, which drives the bus write request
    modport master (
        input  W_R, dato_bin, addr_in, wr_ack,
        output wr_req, wr_addr, wr_data, busy, done, range_err, timeout_err
    );

    // slave: the environment that commits values and acknowledges writes
    modport slave (
        output W_R, dato_bin, addr_in, wr_ack,
        input  wr_req, wr_addr, wr_data, busy, done, range_err, timeout_err
    );
endinterface

// File: rtl/bcd_field_writer.sv
// Converts a 7-bit binary field (clamped to 99) to packed BCD by serial
// double-dabble, then issues one register write and waits for acknowledge.
module bcd_field_writer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_field_writer_if.master   bus
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(ACK_TIMEOUT - 1);
    localparam int NIB = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        REQ     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          w_r_q, w_r_d;
    logic          arm_q, arm_d;
    logic [14:0]   sr_q, sr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          wr_req_q, wr_req_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          range_err_q, range_err_d;
    logic          timeout_err_q, timeout_err_d;

    logic          start;
    logic [6:0]    clamped;
    logic [14:0]   sr_adj;
    logic [14:0]   sr_shift;

    // Shift register layout: {tens[14:11], units[10:7], binary[6:0]}.
    assign sr_adj[6:0] = sr_q[6:0];

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_dabble
            assign sr_adj[7+4*gi +: 4] = (sr_q[7+4*gi +: 4] >= 4'd5)
                                       ? sr_q[7+4*gi +: 4] + 4'd3
                                       : sr_q[7+4*gi +: 4];
        end
    endgenerate

    assign sr_shift = sr_adj << 1;

    assign clamped = (bus.dato_bin > 7'd99) ? 7'd99 : bus.dato_bin;

    // arm_q blocks a start until W_R has been seen low since reset, so a
    // level that was already high across reset cannot trigger a write.
    assign start = bus.W_R & ~w_r_q & arm_q;

    always_comb begin
        state_d       = state_q;
        w_r_d         = bus.W_R;
        arm_d         = arm_q | ~bus.W_R;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        tout_d        = tout_q;
        wr_req_d      = wr_req_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        done_d        = 1'b0;
        range_err_d   = range_err_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wr_addr_d     = bus.addr_in;
                    sr_d          = {8'h00, clamped};
                    range_err_d   = (bus.dato_bin > 7'd99);
                    timeout_err_d = 1'b0;
                    cnt_d         = 3'd7;
                    state_d       = CONVERT;
                end
            end
            CONVERT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    wr_data_d = sr_shift[14:7];
                    wr_req_d  = 1'b1;
                    tout_d    = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.wr_ack) begin
                    wr_req_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (tout_q == TOUT_LAST) begin
                    wr_req_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end
            default: begin
                wr_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            w_r_q         <= 1'b0;
            arm_q         <= ~bus.W_R;
            sr_q          <= '0;
            cnt_q         <= '0;
            tout_q        <= '0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            range_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_r_q         <= w_r_d;
            arm_q         <= arm_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            tout_q        <= tout_d;
            wr_req_q      <= wr_req_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            range_err_q   <= range_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.wr_req      = wr_req_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.range_err   = range_err_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bcd_field_writer.sv
// Self-checking bench for bcd_field_writer: vector table, random writes
// against a decimal reference model, and hand-built timing corner cases.
module tb_bcd_field_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_field_writer_if bus();

    bcd_field_writer #(.ACK_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [6:0] dato;
        logic [7:0] addr;
        int         ack_dly;
        logic [7:0] exp_data;
        logic       exp_rng;
    } vec_t;

    vec_t vecs[8];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected BCD from plain decimal arithmetic on the clamped value.
    function automatic logic [7:0] model_bcd(input int v);
        int m;
        m = (v > 99) ? 99 : v;
        return 8'(((m / 10) << 4) | (m % 10));
    endfunction

    task automatic do_write(input logic [6:0] v, input logic [7:0] a, input int dly,
                            input logic [7:0] exp_d, input logic exp_r, input string tag);
        logic early;
        int   d0;
        early = 1'b0;
        d0    = done_cnt;
        bus.dato_bin = v;
        bus.addr_in  = a;
        bus.W_R      = 1'b1;
        tick();
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        check({tag, "_range"}, 32'(bus.range_err), 32'(exp_r));
        bus.W_R = 1'b0;
        repeat (6) begin
            tick();
            early |= bus.wr_req;
        end
        check({tag, "_early_req"}, 32'(early), 32'd0);
        tick();
        check({tag, "_req_k7"}, 32'(bus.wr_req), 32'd1);
        check({tag, "_data"}, 32'(bus.wr_data), 32'(exp_d));
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'(a));
        repeat (dly) tick();
        check({tag, "_req_hold"}, 32'({bus.wr_req, bus.wr_data}), 32'({1'b1, exp_d}));
        bus.wr_ack = 1'b1;
        tick();
        check({tag, "_done_req_busy"}, 32'({bus.done, bus.wr_req, bus.busy}), 32'b100);
        bus.wr_ack = 1'b0;
        tick();
        check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
        check({tag, "_data_keep"}, 32'(bus.wr_data), 32'(exp_d));
        check({tag, "_range_sticky"}, 32'(bus.range_err), 32'(exp_r));
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        $display("write %s dato=%0d addr=%02h data=%02h range=%0b", tag, v, a, bus.wr_data, bus.range_err);
    endtask

    initial begin
        logic flag;
        int   n;
        int   d0;
        logic [6:0] rv;
        logic [7:0] ra;

        vecs[0] = '{7'd45,  8'h02, 3, 8'h45, 1'b0};
        vecs[1] = '{7'd127, 8'h10, 1, 8'h99, 1'b1};
        vecs[2] = '{7'd0,   8'h11, 0, 8'h00, 1'b0};
        vecs[3] = '{7'd99,  8'hFF, 2, 8'h99, 1'b0};
        vecs[4] = '{7'd100, 8'h80, 0, 8'h99, 1'b1};
        vecs[5] = '{7'd9,   8'h01, 4, 8'h09, 1'b0};
        vecs[6] = '{7'd10,  8'h7E, 1, 8'h10, 1'b0};
        vecs[7] = '{7'd58,  8'hA5, 5, 8'h58, 1'b0};

        bus.W_R = 1'b0; bus.dato_bin = '0; bus.addr_in = '0; bus.wr_ack = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", 32'({bus.wr_req, bus.wr_addr, bus.wr_data, bus.busy,
                                    bus.done, bus.range_err, bus.timeout_err}), 32'd0);

        // Acknowledge while idle must do nothing.
        bus.wr_ack = 1'b1;
        repeat (3) tick();
        check("idle_ack_ignored", 32'({bus.busy, bus.done, bus.wr_req}), 32'd0);
        check("idle_ack_no_done", 32'(done_cnt), 32'd0);
        bus.wr_ack = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            do_write(vecs[i].dato, vecs[i].addr, vecs[i].ack_dly, vecs[i].exp_data,
                     vecs[i].exp_rng, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rv = 7'($urandom_range(0, 127));
            ra = 8'($urandom_range(0, 255));
            do_write(rv, ra, int'($urandom_range(0, 4)), model_bcd(int'(rv)),
                     (rv > 7'd99), $sformatf("rnd%0d", i));
        end

        // Acknowledge never arrives: abort after 255 cycles in REQ.
        d0 = done_cnt;
        bus.dato_bin = 7'd12; bus.addr_in = 8'h44; bus.W_R = 1'b1;
        tick();
        bus.W_R = 1'b0;
        repeat (7) tick();
        check("to_req_up", 32'(bus.wr_req), 32'd1);
        n = 0;
        while (bus.wr_req === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("to_req_cycles", 32'(n), 32'd255);
        check("to_flag_busy", 32'({bus.timeout_err, bus.busy}), 32'b10);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        $display("write timeout req_cycles=%0d timeout_err=%0b", n, bus.timeout_err);

        // Acknowledge on the very edge the timeout would fire.
        d0 = done_cnt;
        bus.dato_bin = 7'd33; bus.addr_in = 8'h45; bus.W_R = 1'b1;
        tick();
        check("tie_start_clears_to", 32'(bus.timeout_err), 32'd0);
        bus.W_R = 1'b0;
        repeat (7) tick();
        repeat (254) tick();
        check("tie_req_before", 32'(bus.wr_req), 32'd1);
        bus.wr_ack = 1'b1;
        tick();
        check("tie_ack_wins", 32'({bus.done, bus.timeout_err, bus.wr_req}), 32'b100);
        bus.wr_ack = 1'b0;
        tick();
        check("tie_done_count", 32'(done_cnt - d0), 32'd1);
        $display("write tie data=%02h done_pulses=%0d", bus.wr_data, done_cnt - d0);

        // Reset three cycles into CONVERT abandons the write.
        bus.dato_bin = 7'd127; bus.addr_in = 8'h66; bus.W_R = 1'b1;
        tick();
        bus.W_R = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_conv_outputs", 32'({bus.wr_req, bus.wr_addr, bus.wr_data, bus.busy,
                                       bus.done, bus.range_err, bus.timeout_err}), 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        flag = 1'b0;
        repeat (12) begin
            tick();
            flag |= bus.wr_req | bus.busy;
        end
        check("rst_conv_no_req", 32'(flag), 32'd0);
        check("rst_conv_no_done", 32'(done_cnt - d0), 32'd0);
        $display("write reset_mid_convert abandoned");

        // W_R high across reset must not start a write.
        bus.W_R = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        flag = 1'b0;
        repeat (10) begin
            tick();
            flag |= bus.busy;
        end
        check("wr_high_after_rst", 32'(flag), 32'd0);
        bus.W_R = 1'b0;
        tick();
        do_write(7'd23, 8'h5A, 1, 8'h23, 1'b0, "rearm");

        // Second rising edge in REQ and a long-held level: one write only.
        d0 = done_cnt;
        bus.dato_bin = 7'd77; bus.addr_in = 8'h33; bus.W_R = 1'b1;
        tick();
        repeat (7) tick();
        check("hold_in_req", 32'(bus.wr_req), 32'd1);
        bus.W_R = 1'b0;
        tick();
        bus.dato_bin = 7'd5; bus.addr_in = 8'h99; bus.W_R = 1'b1;
        tick();
        bus.wr_ack = 1'b1;
        tick();
        bus.wr_ack = 1'b0;
        flag = 1'b0;
        repeat (50) begin
            tick();
            flag |= bus.busy;
        end
        check("hold_no_retrigger", 32'(flag), 32'd0);
        check("hold_one_done", 32'(done_cnt - d0), 32'd1);
        check("hold_data_addr", 32'({bus.wr_data, bus.wr_addr}), 32'h7733);
        $display("write hold data=%02h addr=%02h done_pulses=%0d", bus.wr_data, bus.wr_addr, done_cnt - d0);
        bus.W_R = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
